// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the returned word into IF/ID with stall, flush and redirect control.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_reg_q, pc_reg_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_reg_q + 32'd4;

  always_comb begin
    pc_reg_d     = pc_reg_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    count_d      = count_q;

    // Redirect outranks stall so a taken branch is never lost behind a hazard.
    if (pc_src_e) begin
      pc_reg_d = {pc_target_e[31:2], 2'b00};
    end else if (!stall_f) begin
      pc_reg_d = pc_plus4;
    end

    // A redirect also squashes the wrong-path word currently being fetched.
    if (flush_d || pc_src_e) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = 32'd0;
      ifid_pc4_d   = 32'd0;
      ifid_valid_d = 1'b0;
    end else if (!stall_f) begin
      ifid_instr_d = imem_rdata;
      ifid_pc_d    = pc_reg_q;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
      count_d      = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg_q     <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      pc_reg_q     <= pc_reg_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      count_q      <= count_d;
    end
  end

  assign imem_addr   = pc_reg_q;
  assign instr_d     = ifid_instr_q;
  assign pc_d        = ifid_pc_q;
  assign pc_plus4_d  = ifid_pc4_q;
  assign valid_d     = ifid_valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus queues hand-computed expected
// outputs, a negedge monitor pops and compares them.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0;
  logic        flush_d = 1'b0;
  logic        pc_src_e = 1'b0;
  logic [31:0] pc_target_e = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic        v;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall_f     (stall_f),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .fetch_count (fetch_count)
  );

  // Instruction memory: two fixed words, every other address returns addr ^ 5A5A_0000.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hFFC4_A303;
    if (a == 32'h4) return 32'h0083_2383;
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step%0d %s: got %h expected %h", id, nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(pops, "imem_addr", imem_addr, e.pc);
      chk(pops, "instr_d", instr_d, e.instr);
      chk(pops, "pc_d", pc_d, e.pcd);
      chk(pops, "pc_plus4_d", pc_plus4_d, e.pc4);
      chk(pops, "valid_d", {31'd0, valid_d}, {31'd0, e.v});
      chk(pops, "fetch_count", fetch_count, e.cnt);
      pops++;
    end
  end

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pcd,
                      input logic [31:0] pc4, input logic v, input logic [31:0] cnt);
    exp_t e;
    e.pc = pc; e.instr = instr; e.pcd = pcd; e.pc4 = pc4; e.v = v; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Apply inputs for one cycle, then queue the outputs expected after that edge.
  task automatic step(input logic st, input logic fl, input logic src, input logic [31:0] tgt,
                      input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pcd,
                      input logic [31:0] pc4, input logic v, input logic [31:0] cnt);
    stall_f = st; flush_d = fl; pc_src_e = src; pc_target_e = tgt;
    @(posedge clk);
    #1;
    push(pc, instr, pcd, pc4, v, cnt);
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    push(32'h0, NOP, 32'h0, 32'h0, 1'b0, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Free run from reset
    step(0, 0, 0, 0, 32'h4, 32'hFFC4_A303, 32'h0, 32'h4, 1, 32'd1);
    step(0, 0, 0, 0, 32'h8, 32'h0083_2383, 32'h4, 32'h8, 1, 32'd2);
    // Stall three cycles at pc=8
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 0, 32'h8, 32'h0083_2383, 32'h4, 32'h8, 1, 32'd2);
    step(0, 0, 0, 0, 32'hC, 32'h5A5A_0008, 32'h8, 32'hC, 1, 32'd3);
    step(0, 0, 0, 0, 32'h10, 32'h5A5A_000C, 32'hC, 32'h10, 1, 32'd4);
    // Flush alone at pc=0x10
    step(0, 1, 0, 0, 32'h14, NOP, 32'h0, 32'h0, 0, 32'd4);
    step(0, 0, 0, 0, 32'h18, 32'h5A5A_0014, 32'h14, 32'h18, 1, 32'd5);
    // Redirect to misaligned 0x42 during stall
    step(1, 0, 1, 32'h42, 32'h40, NOP, 32'h0, 32'h0, 0, 32'd5);
    step(0, 0, 0, 0, 32'h44, 32'h5A5A_0040, 32'h40, 32'h44, 1, 32'd6);
    // Stall plus flush: PC holds, bubble
    step(1, 1, 0, 0, 32'h44, NOP, 32'h0, 32'h0, 0, 32'd6);
    step(0, 0, 0, 0, 32'h48, 32'h5A5A_0044, 32'h44, 32'h48, 1, 32'd7);
    // Redirect to top of address space, then wrap
    step(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP, 32'h0, 32'h0, 0, 32'd7);
    step(0, 0, 0, 0, 32'h0, 32'hA5A5_FFFC, 32'hFFFF_FFFC, 32'h0, 1, 32'd8);
    step(0, 0, 0, 0, 32'h4, 32'hFFC4_A303, 32'h0, 32'h4, 1, 32'd9);

    // Asynchronous reset mid-cycle, checked before any further rising edge
    @(negedge clk);
    stall_f = 1'b1; pc_src_e = 1'b1; pc_target_e = 32'h100;
    @(posedge clk);
    #2 rst = 1'b1;
    push(32'h0, NOP, 32'h0, 32'h0, 1'b0, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(0, 0, 0, 0, 32'h4, 32'hFFC4_A303, 32'h0, 32'h4, 1, 32'd1);

    for (int w = 0; w < 50 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
